// File: rtl/mips_exec_control.sv
// Single-cycle MIPS execute/control: decode, 32x32 register file, ALU,
// data-memory port drive and branch/jump redirect generation.
module mips_exec_control (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     inst,
  input  logic [31:0]     inst_addr,
  input  logic [0:3][7:0] mem_data_out,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_data_in,
  output logic            mem_write_en,
  output logic [31:0]     pc_branch,
  output logic            pc_branch_en,
  output logic [27:0]     pc_j,
  output logic            pc_j_en,
  output logic            halted
);

  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic [15:0] imm_s;
  logic [31:0] simm_s, zimm_s, rs_val_s, rt_val_s, br_off_s;

  logic [31:0] regs_r [32];
  logic        halted_r;

  logic [31:0] alu_s, wr_data_s, br_s, mdi_s;
  logic [27:0] j_s;
  logic [4:0]  wr_addr_s;
  logic [1:0]  wr_sel_s;
  logic        wr_en_s, mem_we_s, br_en_s, j_en_s, halt_set_s;

  assign op_s     = inst[31:26];
  assign rs_s     = inst[25:21];
  assign rt_s     = inst[20:16];
  assign rd_s     = inst[15:11];
  assign shamt_s  = inst[10:6];
  assign funct_s  = inst[5:0];
  assign imm_s    = inst[15:0];
  assign simm_s   = {{16{imm_s[15]}}, imm_s};
  assign zimm_s   = {16'h0000, imm_s};
  // $0 is never written, so a plain array read returns zero for it.
  assign rs_val_s = regs_r[rs_s];
  assign rt_val_s = regs_r[rt_s];
  assign br_off_s = 32'd4 + {simm_s[29:0], 2'b00};

  // Instruction decode and ALU.
  always_comb begin
    alu_s      = 32'd0;
    wr_en_s    = 1'b0;
    wr_addr_s  = rt_s;
    wr_sel_s   = 2'd0;
    mem_we_s   = 1'b0;
    mdi_s      = rt_val_s;
    br_s       = 32'd0;
    br_en_s    = 1'b0;
    j_s        = 28'd0;
    j_en_s     = 1'b0;
    halt_set_s = 1'b0;
    case (op_s)
      6'h00: begin
        wr_addr_s = rd_s;
        wr_en_s   = 1'b1;
        case (funct_s)
          6'h20, 6'h21: alu_s = rs_val_s + rt_val_s;
          6'h22, 6'h23: alu_s = rs_val_s - rt_val_s;
          6'h24: alu_s = rs_val_s & rt_val_s;
          6'h25: alu_s = rs_val_s | rt_val_s;
          6'h26: alu_s = rs_val_s ^ rt_val_s;
          6'h27: alu_s = ~(rs_val_s | rt_val_s);
          6'h2A: alu_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)};
          6'h2B: alu_s = {31'd0, rs_val_s < rt_val_s};
          6'h00: alu_s = rt_val_s << shamt_s;
          6'h02: alu_s = rt_val_s >> shamt_s;
          6'h03: alu_s = $signed(rt_val_s) >>> shamt_s;
          6'h04: alu_s = rt_val_s << rs_val_s[4:0];
          6'h06: alu_s = rt_val_s >> rs_val_s[4:0];
          6'h07: alu_s = $signed(rt_val_s) >>> rs_val_s[4:0];
          6'h08: begin
            wr_en_s = 1'b0;
            br_s    = rs_val_s - inst_addr;
            br_en_s = 1'b1;
          end
          6'h0C: begin
            wr_en_s    = 1'b0;
            halt_set_s = 1'b1;
          end
          default: wr_en_s = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin alu_s = rs_val_s + simm_s; wr_en_s = 1'b1; end
      6'h0A: begin alu_s = {31'd0, $signed(rs_val_s) < $signed(simm_s)}; wr_en_s = 1'b1; end
      6'h0B: begin alu_s = {31'd0, rs_val_s < simm_s}; wr_en_s = 1'b1; end
      6'h0C: begin alu_s = rs_val_s & zimm_s; wr_en_s = 1'b1; end
      6'h0D: begin alu_s = rs_val_s | zimm_s; wr_en_s = 1'b1; end
      6'h0E: begin alu_s = rs_val_s ^ zimm_s; wr_en_s = 1'b1; end
      6'h0F: begin alu_s = {imm_s, 16'h0000}; wr_en_s = 1'b1; end
      6'h23: begin alu_s = rs_val_s + simm_s; wr_en_s = 1'b1; wr_sel_s = 2'd1; end
      6'h20: begin alu_s = rs_val_s + simm_s; wr_en_s = 1'b1; wr_sel_s = 2'd2; end
      6'h24: begin alu_s = rs_val_s + simm_s; wr_en_s = 1'b1; wr_sel_s = 2'd3; end
      6'h2B: begin alu_s = rs_val_s + simm_s; mem_we_s = 1'b1; end
      6'h28: begin
        alu_s    = rs_val_s + simm_s;
        mem_we_s = 1'b1;
        mdi_s    = {rt_val_s[7:0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
      end
      6'h04: begin br_s = br_off_s; br_en_s = (rs_val_s == rt_val_s); end
      6'h05: begin br_s = br_off_s; br_en_s = (rs_val_s != rt_val_s); end
      6'h06: begin br_s = br_off_s; br_en_s = rs_val_s[31] | (rs_val_s == 32'd0); end
      6'h07: begin br_s = br_off_s; br_en_s = ~rs_val_s[31] & (rs_val_s != 32'd0); end
      6'h02: begin j_s = {inst[25:0], 2'b00}; j_en_s = 1'b1; end
      // jal routes the link address through the ALU result.
      6'h03: begin
        j_s       = {inst[25:0], 2'b00};
        j_en_s    = 1'b1;
        alu_s     = inst_addr + 32'd4;
        wr_en_s   = 1'b1;
        wr_addr_s = 5'd31;
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  // Register write-back data select (ALU result or load formats).
  always_comb begin
    case (wr_sel_s)
      2'd1:    wr_data_s = mem_data_out;
      2'd2:    wr_data_s = {{24{mem_data_out[0][7]}}, mem_data_out[0]};
      2'd3:    wr_data_s = {24'd0, mem_data_out[0]};
      default: wr_data_s = alu_s;
    endcase
  end

  // Register file write port and sticky halt flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
      halted_r <= 1'b0;
    end else begin
      if (halt_set_s) halted_r <= 1'b1;
      if (wr_en_s && !halted_r && (wr_addr_s != 5'd0)) regs_r[wr_addr_s] <= wr_data_s;
    end
  end

  assign mem_addr     = alu_s;
  assign mem_data_in  = mdi_s;
  assign mem_write_en = mem_we_s & ~halted_r & rst_b;
  assign pc_branch    = br_s;
  assign pc_branch_en = br_en_s & ~halted_r & rst_b;
  assign pc_j         = j_s;
  assign pc_j_en      = j_en_s & ~halted_r & rst_b;
  assign halted       = halted_r;

endmodule

// File: tb/tb_mips_exec_control.sv
// Directed table-driven bench for mips_exec_control plus halt/reset sequences.
module tb_mips_exec_control;

  logic            clk, rst_b;
  logic [31:0]     inst, inst_addr;
  logic [0:3][7:0] mem_data_out;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic            mem_write_en, pc_branch_en, pc_j_en, halted;
  logic [31:0]     pc_branch;
  logic [27:0]     pc_j;

  int n_checks = 0;
  int n_fail   = 0;

  mips_exec_control dut (
    .clk(clk), .rst_b(rst_b), .inst(inst), .inst_addr(inst_addr),
    .mem_data_out(mem_data_out), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .pc_branch(pc_branch), .pc_branch_en(pc_branch_en),
    .pc_j(pc_j), .pc_j_en(pc_j_en), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] mdo;
    logic        chk_mem;
    logic [31:0] maddr;
    logic [31:0] mdi;
    logic        we;
    logic        chk_pc;
    logic [31:0] br;
    logic        br_en;
    logic [27:0] pj;
    logic        j_en;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rt(input logic [4:0] rs, input logic [4:0] rtr,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'h00, rs, rtr, rd, sh, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rtr, input logic [15:0] imm);
    return {op, rs, rtr, imm};
  endfunction

  function automatic logic [31:0] jt(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] a, input logic [31:0] mdo,
                              input logic cm, input logic [31:0] ma, input logic [31:0] md,
                              input logic we, input logic cp, input logic [31:0] br,
                              input logic be, input logic [27:0] pj, input logic je);
    vec_t v;
    v.inst = i; v.addr = a; v.mdo = mdo; v.chk_mem = cm; v.maddr = ma; v.mdi = md;
    v.we = we; v.chk_pc = cp; v.br = br; v.br_en = be; v.pj = pj; v.j_en = je;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] mdo);
    inst = i;
    inst_addr = a;
    mem_data_out = mdo;
  endtask

  initial begin
    // Straight-line ALU / memory program from a clean reset, PC = 0.
    vecs.push_back(mk(it(6'h08,5'd0,5'd1,16'hFFFB),  32'h0, 32'h0, 1'b1, 32'hFFFFFFFB, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h09,5'd0,5'd2,16'h0007),  32'h0, 32'h0, 1'b1, 32'h7, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd1,5'd2,5'd3,5'd0,6'h20), 32'h0, 32'h0, 1'b1, 32'h2, 32'h7, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd1,5'd2,5'd4,5'd0,6'h2A), 32'h0, 32'h0, 1'b1, 32'h1, 32'h7, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd1,5'd2,5'd5,5'd0,6'h2B), 32'h0, 32'h0, 1'b1, 32'h0, 32'h7, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd3,16'h0000),  32'h0, 32'h0, 1'b1, 32'h0, 32'h2, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd4,16'h0004),  32'h0, 32'h0, 1'b1, 32'h4, 32'h1, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd5,16'h0004),  32'h0, 32'h0, 1'b1, 32'h4, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h0F,5'd0,5'd6,16'h8000),  32'h0, 32'h0, 1'b1, 32'h80000000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd0,5'd6,5'd7,5'd4,6'h03), 32'h0, 32'h0, 1'b1, 32'hF8000000, 32'h80000000, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd0,5'd6,5'd8,5'd4,6'h02), 32'h0, 32'h0, 1'b1, 32'h08000000, 32'h80000000, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd0,5'd6,5'd0,5'd1,6'h00), 32'h0, 32'h0, 1'b1, 32'h0, 32'h80000000, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd7,16'h0000),  32'h0, 32'h0, 1'b1, 32'h0, 32'hF8000000, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd8,16'h0000),  32'h0, 32'h0, 1'b1, 32'h0, 32'h08000000, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd0,16'h0000),  32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd2,16'h0008),  32'h0, 32'h80112233, 1'b1, 32'h8, 32'h7, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h23,5'd0,5'd9,16'h0008),  32'h0, 32'h80112233, 1'b1, 32'h8, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h20,5'd0,5'd10,16'h0008), 32'h0, 32'h80112233, 1'b1, 32'h8, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h24,5'd0,5'd11,16'h0008), 32'h0, 32'h80112233, 1'b1, 32'h8, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h28,5'd0,5'd2,16'h000C),  32'h0, 32'hAABBCCDD, 1'b1, 32'hC, 32'h07BBCCDD, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd9,16'h0000),  32'h0, 32'h0, 1'b1, 32'h0, 32'h80112233, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd10,16'h0000), 32'h0, 32'h0, 1'b1, 32'h0, 32'hFFFFFF80, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd11,16'h0000), 32'h0, 32'h0, 1'b1, 32'h0, 32'h00000080, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd2,5'd1,5'd12,5'd0,6'h22),32'h0, 32'h0, 1'b1, 32'hC, 32'hFFFFFFFB, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h0D,5'd0,5'd13,16'hF0F0), 32'h0, 32'h0, 1'b1, 32'h0000F0F0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd0,5'd0,5'd14,5'd0,6'h27),32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd2,5'd6,5'd15,5'd0,6'h07),32'h0, 32'h0, 1'b1, 32'hFF000000, 32'h80000000, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h0B,5'd1,5'd16,16'hFFFF), 32'h0, 32'h0, 1'b1, 32'h1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h0A,5'd1,5'd17,16'hFFFA), 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h08,5'd0,5'd21,16'h0003), 32'h0, 32'h0, 1'b1, 32'h3, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h08,5'd21,5'd21,16'h0004),32'h0, 32'h0, 1'b1, 32'h7, 32'h3, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h0E,5'd2,5'd22,16'h000F), 32'h0, 32'h0, 1'b1, 32'h8, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd1,5'd2,5'd23,5'd0,6'h24),32'h0, 32'h0, 1'b1, 32'h3, 32'h7, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    // Redirects at PC = 0x100.
    vecs.push_back(mk(it(6'h04,5'd2,5'd2,16'hFFFE),  32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h05,5'd2,5'd2,16'h0005),  32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h06,5'd1,5'd0,16'h0003),  32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b1, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h07,5'd1,5'd0,16'h0003),  32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h07,5'd2,5'd0,16'h0001),  32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b1, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h06,5'd0,5'd0,16'h0002),  32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b1, 28'h0, 1'b0));
    vecs.push_back(mk(jt(6'h03,26'h0000040),         32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0000100, 1'b1));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd31,16'h0000), 32'h200, 32'h0, 1'b1, 32'h0, 32'h104, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h08,5'd0,5'd18,16'h0200), 32'h0, 32'h0, 1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd18,5'd0,5'd0,5'd0,6'h08),32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, 28'h0, 1'b0));
    vecs.push_back(mk(jt(6'h02,26'h3FFFFFF),         32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'hFFFFFFC, 1'b1));
    // Unrecognized opcode / funct behave as no-ops.
    vecs.push_back(mk(it(6'h3F,5'd0,5'd0,16'h0000),  32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(rt(5'd1,5'd2,5'd24,5'd0,6'h3F),32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));
    vecs.push_back(mk(it(6'h2B,5'd0,5'd24,16'h0000), 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 28'h0, 1'b0));

    // Reset state with a store presented: enables are forced low.
    rst_b = 1'b0;
    drive(it(6'h2B,5'd0,5'd0,16'h0000), 32'h0, 32'h0);
    #3;
    chk("reset halted", {31'd0, halted}, 32'h0);
    chk("reset mem_write_en", {31'd0, mem_write_en}, 32'h0);
    chk("reset pc_branch_en", {31'd0, pc_branch_en}, 32'h0);
    chk("reset pc_j_en", {31'd0, pc_j_en}, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].inst, vecs[i].addr, vecs[i].mdo);
      #1;
      if (vecs[i].chk_mem) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
        chk($sformatf("v%0d mem_data_in", i), mem_data_in, vecs[i].mdi);
      end
      chk($sformatf("v%0d mem_write_en", i), {31'd0, mem_write_en}, {31'd0, vecs[i].we});
      if (vecs[i].chk_pc) begin
        chk($sformatf("v%0d pc_branch", i), pc_branch, vecs[i].br);
        chk($sformatf("v%0d pc_j", i), {4'd0, pc_j}, {4'd0, vecs[i].pj});
      end
      chk($sformatf("v%0d pc_branch_en", i), {31'd0, pc_branch_en}, {31'd0, vecs[i].br_en});
      chk($sformatf("v%0d pc_j_en", i), {31'd0, pc_j_en}, {31'd0, vecs[i].j_en});
      @(posedge clk);
      @(negedge clk);
    end

    // syscall: halted rises only at the clock edge.
    drive(rt(5'd0,5'd0,5'd0,5'd0,6'h0C), 32'h0, 32'h0);
    #1 chk("syscall halted before edge", {31'd0, halted}, 32'h0);
    @(posedge clk); #1;
    chk("syscall halted after edge", {31'd0, halted}, 32'h1);
    @(negedge clk);
    drive(it(6'h08,5'd0,5'd19,16'h0001), 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    drive(it(6'h2B,5'd0,5'd19,16'h0000), 32'h0, 32'h0);
    #1;
    chk("halted no reg write", mem_data_in, 32'h0);
    chk("halted mem_write_en", {31'd0, mem_write_en}, 32'h0);
    drive(it(6'h04,5'd0,5'd0,16'h0001), 32'h0, 32'h0);
    #1 chk("halted pc_branch_en", {31'd0, pc_branch_en}, 32'h0);
    drive(jt(6'h02,26'h0000010), 32'h0, 32'h0);
    #1 chk("halted pc_j_en", {31'd0, pc_j_en}, 32'h0);
    drive(it(6'h2B,5'd0,5'd2,16'h0008), 32'h0, 32'h0);
    #1 chk("halted regs kept", mem_data_in, 32'h7);

    // Asynchronous reset mid-cycle clears halt and registers at once.
    rst_b = 1'b0;
    #1;
    chk("async reset halted", {31'd0, halted}, 32'h0);
    chk("async reset regs", mem_data_in, 32'h0);
    drive(it(6'h08,5'd0,5'd20,16'h0005), 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    rst_b = 1'b1;
    drive(it(6'h2B,5'd0,5'd20,16'h0000), 32'h0, 32'h0);
    #1;
    chk("write during reset discarded", mem_data_in, 32'h0);
    chk("post reset mem_write_en", {31'd0, mem_write_en}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_exec_control.md
# mips_exec_control

Single-cycle execute/control block for the MIPS core. It decodes the current instruction, holds the 32×32 register file, and computes results with an internal ALU. It drives the byte-wide data-memory port and returns branch/jump redirect requests to the core's PC logic. The PC register, instruction memory and data memory live outside this block.

## Interface
Parameters: none.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_b`  in  1  — reset, asynchronous and active-low.
- `inst`  in  32  — current instruction word.
- `inst_addr`  in  32  — address of `inst`, the current PC.
- `mem_data_out`  in  4×8  — data-memory read bytes `[0:3]`. Combinational read of `mem_addr`.
- `mem_addr`  out  32  — data-memory byte address.
- `mem_data_in`  out  4×8  — data-memory write bytes `[0:3]`.
- `mem_write_en`  out  1  — memory writes `mem_data_in` at `mem_addr` on the next rising edge.
- `pc_branch`  out  32  — PC offset. The core loads `inst_addr + pc_branch`.
- `pc_branch_en`  out  1  — selects `pc_branch`. Has priority over `pc_j_en`.
- `pc_j`  out  28  — jump target low bits. The core loads `{inst_addr[31:28], pc_j}`.
- `pc_j_en`  out  1  — selects `pc_j`.
- `halted`  out  1  — sticky halt flag.

## Operation
- Instruction fields:
  - `op = inst[31:26]`, `rs = [25:21]`, `rt = [20:16]`, `rd = [15:11]`, `shamt = [10:6]`, `funct = [5:0]`.
  - `imm = [15:0]`, `target = [25:0]`.
- Register file: 32×32. `$0` reads as 0 and ignores writes. Two combinational read ports (`rs`, `rt`) and one write port, written on the rising edge.
- Internal ALU: combinational, 32-bit. Add and subtract wrap modulo 2^32; there are no overflow traps.
- Signed compares use two's complement. Shifts use amount[4:0].
- R-type (`op=0`), by funct, writing `rd`:
  - `add`/`addu` 20/21, `sub`/`subu` 22/23.
  - `and` 24, `or` 25, `xor` 26, `nor` 27.
  - `slt` 2A, `sltu` 2B.
  - `sll` 00, `srl` 02, `sra` 03 (shift `rt` by `shamt`).
  - `sllv` 04, `srlv` 06, `srav` 07 (shift `rt` by `rs[4:0]`).
  - `jr` 08: `pc_branch = rs − inst_addr`, `pc_branch_en = 1`, no register write.
  - `syscall` 0C: halts.
- I-type, writing `rt`:
  - Sign-extended immediate: `addi` 08, `addiu` 09, `slti` 0A, `sltiu` 0B (sign-extend, then unsigned compare).
  - Zero-extended immediate: `andi` 0C, `ori` 0D, `xori` 0E.
  - `lui` 0F: `{imm, 16'h0}`.
- Memory, big-endian: byte[0] is bits 31:24. Address is `rs + sext(imm)`; alignment is not checked.
  - `lw` 23: `rt = {b0,b1,b2,b3}`.
  - `lb` 20: `rt = sext(b0)`.
  - `lbu` 24: `rt = zext(b0)`.
  - `sw` 2B: `mem_data_in` gets `rt` bytes, `mem_write_en = 1`.
  - `sb` 28: byte[0] = `rt[7:0]`, bytes[1:3] = `mem_data_out[1:3]` (preserved), `mem_write_en = 1`.
- Branches: `pc_branch = 4 + (sext(imm)<<2)`, `pc_branch_en = 1` only when taken.
  - `beq` 04: taken if `rs == rt`.
  - `bne` 05: taken if `rs != rt`.
  - `blez` 06: taken if `rs ≤ 0` (signed).
  - `bgtz` 07: taken if `rs > 0` (signed).
- Jumps:
  - `j` 02: `pc_j = {target, 2'b00}`, `pc_j_en = 1`.
  - `jal` 03: same as `j`, and `$31 = inst_addr + 4`.
- Unrecognized opcode or funct: no-op (no writes, no redirect).
- Defaults when an output is unused:
  - `mem_addr` = ALU output.
  - `mem_data_in` = `rt` bytes.
  - `pc_branch` = 0.
  - `pc_j` = 0.

## Timing
- All decode, ALU, memory-address and redirect outputs are combinational from `inst`, `inst_addr`, register contents and `mem_data_out`. Latency is 0 cycles.
- Register-file writes and the `halted` set occur on the rising edge that ends the instruction's cycle.
- Loads complete in one cycle, so back-to-back dependent instructions see the updated register.
- `syscall` sets `halted` at that edge. `halted` stays 1 until reset.
- While `halted = 1`:
  - No register writes.
  - `mem_write_en = 0`.
  - `pc_branch_en = 0` and `pc_j_en = 0`.
- Reset (`rst_b = 0`), asynchronous and effective mid-instruction:
  - All 32 registers clear to 0 and `halted` clears to 0.
  - While `rst_b` is low: `mem_write_en`, `pc_branch_en` and `pc_j_en` are forced to 0.
  - Any write pending on the next edge is discarded.
- Concurrent `rs`/`rt` read and write to the same register in one cycle: the read returns the old value.

## Test plan
- Reset, then `addi $1,$0,-5` followed by `addiu $2,$0,7`; `add $3,$1,$2` → `$3 = 2`; `slt $4,$1,$2` → 1; `sltu $5,$1,$2` → 0.
- `lui $6,0x8000` then `sra $7,$6,4` → `$7 = 0xF8000000`; `srl` → `0x08000000`; `sll $0,$6,1` leaves `$0 = 0`.
- `sw $2,8($0)`: `mem_addr = 8`, `mem_data_in = {00,00,00,07}`, `mem_write_en = 1`. With `mem_data_out = {80,11,22,33}`: `lw` → `0x80112233`, `lb` → `0xFFFFFF80`.
- At `inst_addr = 0x100`:
  - `beq` equal, `imm = −2` → `pc_branch = 0xFFFFFFFC`, `pc_branch_en = 1`.
  - `bne` on equal operands → `pc_branch_en = 0`.
  - `jal` `target = 0x40` → `pc_j = 0x100`, `pc_j_en = 1`, `$31 = 0x104`.
  - `jr` with `rs = 0x200` → `pc_branch = 0x100`.
- `syscall` → `halted` rises at the edge. A following `sw`/`addi` produces no writes and `mem_write_en = 0`. Asserting `rst_b = 0` clears `halted` and the registers immediately, without waiting for a clock edge.
